// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract, one CHUNK-bit slice resolved per stage
// Carry ripples stage to stage; a single advance signal freezes the whole pipe under backpressure.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic             r_v [STAGES];
  logic             r_c [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];

  logic             w_v_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];
  logic             w_c_nxt [STAGES];
  logic             w_adv;

  assign w_adv    = !r_v[LAST] || out_ready;
  assign in_ready = w_adv;

  genvar k;
  for (k = 0; k < STAGES; k = k + 1) begin : g_stage
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_sum;

    // Stage 0 feeds from the ports (operand B already conditioned for subtract).
    if (k == 0) begin : g_head
      assign w_v_in[k] = in_valid;
      assign w_a_in[k] = a;
      assign w_b_in[k] = b ^ {WIDTH{sub}};
      assign w_c_in[k] = ci ^ sub;
      assign w_s_in[k] = '0;
    end else begin : g_tail
      assign w_v_in[k] = r_v[k-1];
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_s_in[k] = r_s[k-1];
    end

    assign w_slice = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                   + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_c_in[k]};

    always_comb begin
      w_sum = w_s_in[k];
      w_sum[k*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
    end

    assign w_s_nxt[k] = w_sum;
    assign w_c_nxt[k] = w_slice[CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= 1'b0;
        r_c[i] <= 1'b0;
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_s[i] <= '0;
      end
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= w_v_in[i];
        r_c[i] <= w_c_nxt[i];
        r_a[i] <= w_a_in[i];
        r_b[i] <= w_b_in[i];
        r_s[i] <= w_s_nxt[i];
      end
    end
  end

  assign out_valid = r_v[LAST];
  assign s         = r_s[LAST];
  assign co        = r_c[LAST];
  // Carry into the MSB is recovered from the MSB operand and sum bits.
  assign ovf       = r_c[LAST] ^ r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ r_s[LAST][WIDTH-1];

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes. It generalises the team's 4-bit registered adder to any width. Each pipeline stage resolves one CHUNK-bit slice and the carry ripples stage to stage, so the critical path is one chunk adder regardless of WIDTH. It sits between operand-producing datapath blocks and downstream consumers, sustains one operation per cycle, and freezes cleanly under backpressure.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a positive multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipeline can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: add; 1: subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  result.
- co  output  1  raw carry out of the MSB.
- ovf  output  1  signed overflow.

## Operation
- Arithmetic: B' = b XOR {WIDTH{sub}} and c0 = ci XOR sub. Then {co, s} = a + B' + c0, computed modulo 2^(WIDTH+1).
  - sub=0: s = a + b + ci.
  - sub=1: s = a - b - ci; co=1 means no borrow.
- ovf = carry into the MSB XOR co, i.e. the signed result does not fit.
- Stage k (0..STAGES-1) adds slice [k*CHUNK +: CHUNK] of a and B' with the carry registered by stage k-1; stage 0 uses c0.
- Slices above k travel in skew registers. Sum slices already resolved are carried forward, so the final stage holds the complete s, co and ovf.
- Each stage has a valid bit. advance = !out_valid || out_ready.
  - When advance=1, all stages shift by one; stage 0 loads {a, B', c0, in_valid}.
  - When advance=0, every register holds.
- in_ready = advance. This is combinational from out_ready and out_valid, with no path from in_valid.
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Bubbles are not collapsed: an empty stage still takes one cycle to traverse.
- Data registers of invalid stages are don't-care internally. Outputs s/co/ovf are meaningful only when out_valid=1.

## Timing
- Reset (rst_n=0, asynchronous): every valid bit, data register and carry register clears to 0. Outputs are out_valid=0, s=0, co=0, ovf=0, and in_ready=1 (because out_valid=0).
- Release: the first accept is possible on the first rising edge with rst_n=1.
- Latency: a beat accepted at edge N appears on out_valid/s after edge N+STAGES-1, i.e. it is visible for the cycle following that edge, provided there are no stalls. With STAGES=1 the result is visible the cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 && out_ready=0, the result holds stable, in_ready=0, and no beat is lost or duplicated.
- Simultaneous consume and accept in the same cycle is legal and required for full throughput.
- Reset mid-operation discards every in-flight beat immediately; out_valid drops asynchronously.
- Wrap-around: s wraps modulo 2^WIDTH, and overflow is reported only via co/ovf.

## Test plan
- Default params (WIDTH=16, CHUNK=4), out_ready=1:
  - a=0xFFFF, b=0x0001, ci=0, sub=0 -> out_valid exactly 4 cycles after accept, with s=0x0000, co=1, ovf=0.
  - a=0x7FFF, b=0x0001, ci=0, sub=0 -> s=0x8000, co=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, ci=0, sub=1 -> s=0xFFFE, co=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
- Stream of 20 random beats back-to-back, with out_ready deasserted for 3 cycles mid-stream:
  - in_ready=0 during the stall and s is held.
  - All 20 results arrive in order and match the reference model, with no drops or duplicates.
- Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; after release no stale beat ever emerges, and in_ready=1.
- WIDTH=4, CHUNK=4 (single stage):
  - a=1111, b=1111, ci=1 -> s=1111, co=1, latency 1.
  - a=1000, b=1000, ci=0 -> s=0000, co=1, ovf=1.
  - a=0110, b=1001, ci=1 -> s=0000, co=1, ovf=0.
